// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared constants and types for the N-channel registered multiplexer.
//   MODE_FIXED / MODE_RR : encodings of the 'mode' input
//   DEFAULT_CHANNELS/WIDTH : default parameter values for mux_nx1_rr
//   state_e : occupancy state of the one-entry output register
// -----------------------------------------------------------------------------
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int DEFAULT_CHANNELS = 4;
    localparam int DEFAULT_WIDTH    = 8;

    // The encoding matches out_valid, so FULL literally means "holds a word".
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational rotating-priority arbiter. It grants the first set
// request found when searching upward from 'ptr', wrapping CHANNELS-1 -> 0.
// CHANNELS does not need to be a power of two.
//   req     : per-channel request
//   ptr     : highest-priority channel index (always < CHANNELS)
//   gnt     : one-hot grant
//   gnt_idx : index of the granted channel (0 when nothing is granted)
//   gnt_any : some channel was granted
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic [CHANNELS-1:0] gnt,
    output logic [SEL_W-1:0]    gnt_idx,
    output logic                gnt_any
);

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that leaves one unassigned infers a latch.
    always_comb begin
        int               idx;
        logic [SEL_W-1:0] idx_s;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        idx_s   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            // Modulo by subtraction: ptr < CHANNELS, so one wrap is enough.
            idx = int'(ptr) + k;
            if (idx >= CHANNELS) begin
                idx = idx - CHANNELS;
            end
            idx_s = SEL_W'(idx);
            if (!gnt_any && req[idx_s]) begin
                gnt[idx_s] = 1'b1;
                gnt_idx    = idx_s;
                gnt_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_nx1_rr.sv
// -----------------------------------------------------------------------------
// mux_nx1_rr
// N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes.
// One channel per cycle is chosen by 'sel' (fixed mode) or by round-robin
// arbitration (RR mode) and captured into a one-entry output register.
//   clk, rst_n          : clock, asynchronous active-low reset
//   mode                : 0 = fixed select, 1 = round-robin
//   sel                 : channel index used in fixed mode
//   in_valid / in_ready : per-channel handshake (at most one in_ready high)
//   in_data             : channel i at bits [i*WIDTH +: WIDTH]
//   out_valid/out_ready : output handshake
//   out_data, out_chan  : registered word and the channel it came from
// -----------------------------------------------------------------------------
module mux_nx1_rr
    import mux_pkg::*;
#(
    parameter  int CHANNELS = DEFAULT_CHANNELS,
    parameter  int WIDTH    = DEFAULT_WIDTH,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    input  logic                      out_ready
);

    state_e              state, state_next;
    logic [SEL_W-1:0]    ptr;
    logic [CHANNELS-1:0] rr_gnt;
    logic [SEL_W-1:0]    rr_idx;
    logic                rr_any;
    logic [CHANNELS-1:0] grant;
    logic [SEL_W-1:0]    grant_idx;
    logic [WIDTH-1:0]    grant_word;
    logic                free;
    logic                xfer;

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_arb (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx),
        .gnt_any (rr_any)
    );

    // Candidate selection. In fixed mode an out-of-range sel (possible when
    // CHANNELS is not a power of two) grants nothing.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        if (mode == MODE_RR) begin
            grant     = rr_gnt;
            grant_idx = rr_idx;
        end else if (int'(sel) < CHANNELS) begin
            grant[sel] = in_valid[sel];
            grant_idx  = sel;
        end
    end

    // One-hot AND-OR mux; avoids an out-of-range part-select on grant_idx.
    always_comb begin
        grant_word = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant[i]) begin
                grant_word = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign out_valid = (state == ST_FULL);
    assign free      = ~out_valid | out_ready;
    // in_ready depends only on in_valid through grant, never the reverse.
    assign in_ready  = rst_n ? (grant & {CHANNELS{free}}) : '0;
    assign xfer      = |in_ready;

    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: if (xfer) state_next = ST_FULL;
            ST_FULL: begin
                if (xfer)           state_next = ST_FULL;
                else if (out_ready) state_next = ST_EMPTY;
            end
            default:  state_next = ST_EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: out_data/out_chan are reset too, so they read 0 after reset
    // instead of stale or unknown values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_chan <= '0;
            ptr      <= '0;
        end else if (xfer) begin
            out_data <= grant_word;
            out_chan <= grant_idx;
            if (mode == MODE_RR) begin
                ptr <= (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

endmodule
